// File: rtl/step_ctrl.sv
// Step controller: debounced push-button or free-running divider bit -> one-cycle cpu_en pulses.
// cpu_en is registered one cycle after a run-bit edge or FIRE; no backpressure, step_cnt wraps.
module step_ctrl #(
  parameter int DB_BIT = 17,
  parameter int DB_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clkdiv,
  input  logic        SW2,
  input  logic        run,
  input  logic        step_btn,
  output logic        cpu_en,
  output logic [15:0] step_cnt,
  output logic        btn_level,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMING = 2'b01,
    FIRE   = 2'b10,
    HELD   = 2'b11
  } db_state_t;

  localparam logic [3:0] DB_LIMIT = 4'(DB_CNT);

  logic      btn_m;
  logic      btn_s;
  logic      primed;
  logic      db_prev;
  logic      run2_prev;
  logic      run24_prev;
  logic      db_tick;
  logic      run_edge;
  db_state_t st;
  logic [3:0] agree;
  logic [3:0] agree_inc;
  logic      unused_clkdiv;

  assign unused_clkdiv = ^clkdiv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= step_btn;
      btn_s <= btn_m;
    end
  end

  // Both run bits keep their own history so a SW2 flip never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed     <= 1'b0;
      db_prev    <= 1'b0;
      run2_prev  <= 1'b0;
      run24_prev <= 1'b0;
    end else begin
      primed     <= 1'b1;
      db_prev    <= clkdiv[DB_BIT];
      run2_prev  <= clkdiv[2];
      run24_prev <= clkdiv[24];
    end
  end

  assign db_tick   = primed & clkdiv[DB_BIT] & ~db_prev;
  assign run_edge  = primed & (SW2 ? (clkdiv[24] & ~run24_prev)
                                   : (clkdiv[2]  & ~run2_prev));
  assign agree_inc = agree + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      agree     <= 4'd0;
      btn_level <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          agree <= 4'd0;
          if (db_tick && btn_s) begin
            st    <= ARMING;
            agree <= 4'd1;
          end
        end
        ARMING: begin
          if (db_tick) begin
            if (!btn_s) begin
              st    <= IDLE;
              agree <= 4'd0;
            end else if (agree_inc == DB_LIMIT) begin
              st        <= FIRE;
              agree     <= 4'd0;
              btn_level <= 1'b1;
            end else begin
              agree <= agree_inc;
            end
          end
        end
        FIRE: begin
          st    <= HELD;
          agree <= 4'd0;
        end
        HELD: begin
          if (db_tick) begin
            if (btn_s) begin
              agree <= 4'd0;
            end else if (agree_inc == DB_LIMIT) begin
              st        <= IDLE;
              agree     <= 4'd0;
              btn_level <= 1'b0;
            end else begin
              agree <= agree_inc;
            end
          end
        end
        default: begin
          st        <= IDLE;
          agree     <= 4'd0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_en   <= 1'b0;
      step_cnt <= 16'd0;
    end else begin
      cpu_en   <= run ? run_edge : (st == FIRE);
      step_cnt <= step_cnt + {15'd0, cpu_en};
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with DB_BIT=4, DB_CNT=4; clkdiv from a counter model or driven by hand.
module tb_step_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] clkdiv;
  logic        SW2;
  logic        run;
  logic        step_btn;
  logic        cpu_en;
  logic [15:0] step_cnt;
  logic        btn_level;
  logic [1:0]  state;

  logic [31:0] cd_cnt;
  logic [31:0] cd_man;
  logic        cd_manual;
  logic        gap_en;

  int          vecs = 0;
  int          errs = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          prev_cyc = 0;
  bit          have_prev = 0;
  int          gmin = 1000;
  int          gmax = 0;
  logic [15:0] seq = 16'd0;
  int          nseq = 0;
  logic [1:0]  last_state = 2'b00;

  int          p0;
  int          n0;
  bit          found;

  step_ctrl #(.DB_BIT(4), .DB_CNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clkdiv    (clkdiv),
    .SW2       (SW2),
    .run       (run),
    .step_btn  (step_btn),
    .cpu_en    (cpu_en),
    .step_cnt  (step_cnt),
    .btn_level (btn_level),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cd_cnt <= 32'd0;
    else     cd_cnt <= cd_cnt + 32'd1;
  end

  assign clkdiv = cd_manual ? cd_man : cd_cnt;

  // Observer: pulse count, pulse spacing and state-change log, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    cyc <= cyc + 1;
    if (cpu_en) begin
      pulses    <= pulses + 1;
      prev_cyc  <= cyc;
      have_prev <= gap_en;
      if (gap_en && have_prev) begin
        if (cyc - prev_cyc < gmin) gmin <= cyc - prev_cyc;
        if (cyc - prev_cyc > gmax) gmax <= cyc - prev_cyc;
      end
    end
    if (!gap_en) begin
      gmin      <= 1000;
      gmax      <= 0;
      have_prev <= 1'b0;
    end
    if (state != last_state) begin
      seq        <= {seq[13:0], state};
      nseq       <= nseq + 1;
      last_state <= state;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; SW2 = 1'b0; step_btn = 1'b0;
    cd_manual = 1'b0; cd_man = 32'd0; gap_en = 1'b0;
    wait_cyc(3);
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_step_cnt", {16'd0, step_cnt}, 32'd0);
    chk("rst_btn_level", {31'd0, btn_level}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    rst = 1'b0;
    wait_cyc(10);

    // Clean press and release in step mode
    p0 = pulses; n0 = nseq;
    step_btn = 1'b1;
    wait_cyc(200);
    chk("clean_state_held", {30'd0, state}, 32'd3);
    chk("clean_level_high", {31'd0, btn_level}, 32'd1);
    step_btn = 1'b0;
    wait_cyc(200);
    chk("clean_pulses", pulses - p0, 32'd1);
    chk("clean_step_cnt", {16'd0, step_cnt}, 32'd1);
    chk("clean_nseq", nseq - n0, 32'd4);
    chk("clean_seq", {24'd0, seq[7:0]}, 32'h6C);
    chk("clean_level_low", {31'd0, btn_level}, 32'd0);

    // Bounce: 40-clk toggles never give 4 agreeing ticks
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      step_btn = (i % 2 == 0);
      wait_cyc(40);
    end
    chk("bounce_no_pulse", pulses - p0, 32'd0);
    step_btn = 1'b1;
    wait_cyc(200);
    chk("bounce_one_pulse", pulses - p0, 32'd1);
    chk("bounce_step_cnt", {16'd0, step_cnt}, 32'd2);
    chk("bounce_level", {31'd0, btn_level}, 32'd1);
    step_btn = 1'b0;
    wait_cyc(200);
    chk("bounce_idle", {30'd0, state}, 32'd0);

    // Free-run on clkdiv[2], then a press inside the run window
    run = 1'b1; SW2 = 1'b0; gap_en = 1'b1;
    p0 = pulses;
    wait_cyc(64);
    chk("run_pulses_64", pulses - p0, 32'd8);
    p0 = pulses;
    step_btn = 1'b1;
    wait_cyc(200);
    chk("run_press_pulses_200", pulses - p0, 32'd25);
    chk("run_press_held", {30'd0, state}, 32'd3);
    chk("run_gap_min", gmin, 32'd8);
    chk("run_gap_max", gmax, 32'd8);
    gap_en = 1'b0;

    // Leave run mode while HELD
    run = 1'b0;
    p0 = pulses;
    wait_cyc(16);
    chk("switch_no_pulse", pulses - p0, 32'd0);
    chk("switch_step_cnt", {16'd0, step_cnt}, 32'd35);
    chk("switch_still_held", {30'd0, state}, 32'd3);
    step_btn = 1'b0;
    wait_cyc(200);
    chk("switch_release_no_pulse", pulses - p0, 32'd0);
    chk("switch_idle", {30'd0, state}, 32'd0);
    step_btn = 1'b1;
    wait_cyc(200);
    chk("switch_next_press", pulses - p0, 32'd1);
    chk("switch_next_cnt", {16'd0, step_cnt}, 32'd36);
    step_btn = 1'b0;
    wait_cyc(200);

    // Reset in ARMING after two high ticks
    step_btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (state == 2'd1) found = 1'b1;
    end
    chk("arming_reached", {31'd0, found}, 32'd1);
    wait_cyc(40);
    chk("arming_before_rst", {30'd0, state}, 32'd1);
    p0 = pulses;
    rst = 1'b1;
    #1;
    chk("midrst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("midrst_step_cnt", {16'd0, step_cnt}, 32'd0);
    chk("midrst_level", {31'd0, btn_level}, 32'd0);
    chk("midrst_state", {30'd0, state}, 32'd0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(100);
    chk("rearm_no_pulse_yet", pulses - p0, 32'd0);
    chk("rearm_arming", {30'd0, state}, 32'd1);
    wait_cyc(50);
    chk("rearm_pulse", pulses - p0, 32'd1);
    chk("rearm_step_cnt", {16'd0, step_cnt}, 32'd1);
    chk("rearm_held", {30'd0, state}, 32'd3);

    // Hand-driven clkdiv: priming cycle, SW2 flip, then counter wrap
    step_btn = 1'b0; run = 1'b1; SW2 = 1'b0;
    cd_manual = 1'b1; cd_man = 32'h0000_0004;
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    p0 = pulses;
    wait_cyc(6);
    chk("prime_no_edge", pulses - p0, 32'd0);
    chk("prime_step_cnt", {16'd0, step_cnt}, 32'd0);
    cd_man = 32'h0100_0000;
    wait_cyc(4);
    SW2 = 1'b1;
    wait_cyc(4);
    chk("sw2_flip_no_pulse", pulses - p0, 32'd0);
    cd_man = 32'd0;
    wait_cyc(2);
    cd_man = 32'h0100_0000;
    wait_cyc(4);
    chk("sw2_new_edge", pulses - p0, 32'd1);
    chk("sw2_step_cnt", {16'd0, step_cnt}, 32'd1);

    for (int i = 0; i < 65533; i++) begin
      if (i % 2 == 0) begin
        cd_man = 32'h0000_0004; SW2 = 1'b0;
      end else begin
        cd_man = 32'h0100_0000; SW2 = 1'b1;
      end
      @(negedge clk);
    end
    cd_man = 32'd0; SW2 = 1'b0;
    wait_cyc(4);
    chk("wrap_fffe", {16'd0, step_cnt}, 32'h0000_FFFE);
    cd_man = 32'h0000_0004;
    wait_cyc(1);
    cd_man = 32'd0;
    wait_cyc(4);
    chk("wrap_ffff", {16'd0, step_cnt}, 32'h0000_FFFF);
    cd_man = 32'h0000_0004;
    wait_cyc(1);
    cd_man = 32'd0;
    wait_cyc(4);
    chk("wrap_0000", {16'd0, step_cnt}, 32'h0000_0000);
    chk("wrap_pulses", pulses - p0, 32'd65536);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Parameters
REQ-001 DB_BIT, default 17, clkdiv bit whose rising edge is the debounce sample tick.
REQ-002 DB_CNT, default 4, range 2..15, consecutive agreeing ticks needed to change the debounced level.

Interface
REQ-003 clk  input  1  system clock, also the clock of the upstream clock divider.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clkdiv  input  32  free-running divider count from the upstream divider, synchronous to clk.
REQ-006 SW2  input  1  run-speed select: 1 = clkdiv[24], 0 = clkdiv[2].
REQ-007 run  input  1  1 = free-run mode, 0 = single-step mode; treated as static or synchronous.
REQ-008 step_btn  input  1  raw asynchronous push-button, active-high, bouncing.
REQ-009 cpu_en  output  1  one-cycle CPU clock-enable pulse.
REQ-010 step_cnt  output  16  count of cpu_en pulses since reset.
REQ-011 btn_level  output  1  debounced button level.
REQ-012 state  output  2  debounce FSM state: 00 IDLE, 01 ARMING, 10 FIRE, 11 HELD.

Function
REQ-013 step_btn SHALL pass through a 2-flop synchronizer; the FSM uses only the synchronized value (btn_s).
REQ-014 The block SHALL detect rising edges of clkdiv[DB_BIT] and of the selected run bit (SW2 ? clkdiv[24] : clkdiv[2]) as bit==1 and registered previous value==0.
REQ-015 The first clk cycle after reset release SHALL only load the previous-value registers; no edge SHALL be reported in that cycle.
REQ-016 A 4-bit agree counter SHALL count consecutive ticks on which btn_s matches the level being tested; it clears on every state change and on every tick that disagrees.
REQ-017 IDLE: on a tick with btn_s=1, go to ARMING with count=1; other cycles stay.
REQ-018 ARMING: on a tick with btn_s=0, return to IDLE; on a tick with btn_s=1, increment the count; when the count reaches DB_CNT, go to FIRE.
REQ-019 FIRE SHALL last exactly one clk cycle and then go to HELD unconditionally.
REQ-020 HELD: count ticks with btn_s=0; a tick with btn_s=1 clears the count; when the count reaches DB_CNT, go to IDLE.
REQ-021 btn_level SHALL be 1 in FIRE and HELD and 0 in IDLE and ARMING.
REQ-022 With run=1, cpu_en SHALL be 1 for exactly the one cycle after each detected rising edge of the selected run bit; FIRE SHALL be ignored.
REQ-023 With run=0, cpu_en SHALL be 1 for exactly the one cycle after the FSM is in FIRE; run-bit edges SHALL be ignored.
REQ-024 cpu_en SHALL be registered, and there SHALL be no more than one pulse per edge or FIRE.
REQ-025 The edge-history registers SHALL update every cycle regardless of run or SW2.
REQ-026 A change of run or SW2 SHALL produce a pulse only if the newly selected bit rises after the change.
REQ-027 step_cnt SHALL increment by 1 in the cycle cpu_en is 1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-028 The debounce FSM SHALL keep running in both modes.
REQ-029 A mode change while in HELD SHALL NOT generate a retroactive step.

Reset
REQ-030 While rst=1, all of the following SHALL hold: state=IDLE, count=0, synchronizer and edge-history registers=0, cpu_en=0, step_cnt=0, btn_level=0.
REQ-031 Reset asserted mid-operation (for example in ARMING or FIRE) SHALL abort without any cpu_en pulse, and the FSM SHALL restart from IDLE.

Verification (DB_BIT=4, DB_CNT=4, clkdiv driven by a counter model reset to 0; sample tick every 32 clk)
REQ-032 Clean step: run=0, hold step_btn=1 for 200 clk, then release for 200 clk -> exactly one cpu_en pulse, step_cnt=1, state sequence IDLE,ARMING,FIRE,HELD,IDLE.
REQ-033 Bounce: run=0, toggle step_btn every 40 clk for 400 clk, then hold it at 1 for 200 clk -> no pulse during toggling, exactly one pulse after the 4th consecutive high tick.
REQ-034 Run mode: run=1, SW2=0, 64 clk -> cpu_en pulses 8 times, 8 clk apart, step_cnt=8; a button press in the same window adds no pulse.
REQ-035 Mode switch: run=1 to run=0 while in HELD -> no pulse at the switch; step_cnt is unchanged until the next press.
REQ-036 Reset mid-ARMING: assert rst after 2 high ticks -> all outputs read 0 at once; after release, the button still held -> a pulse only after 4 new high ticks.
REQ-037 Wrap: force step_cnt=0xFFFE via 2 steps from a preloaded bench -> reads 0xFFFF, then 0x0000.
